// File: rtl/water_zone_ctrl_pkg.sv
// Shared constants for the irrigation zone controller: state encodings,
// default thresholds and the zone index type.
package water_zone_ctrl_pkg;

  localparam int DEF_N_ZONES     = 4;
  localparam int DEF_MOIST_W     = 8;
  localparam int DEF_DRY_TH      = 64;
  localparam int DEF_WET_TH      = 128;
  localparam int DEF_LVL_W       = 2;
  localparam int DEF_PUMP_MIN_ON = 8;
  localparam int DEF_WATER_MAX   = 16;

  localparam logic [0:0] P_OFF   = 1'b0;
  localparam logic [0:0] P_ON    = 1'b1;
  localparam logic [0:0] Z_IDLE  = 1'b0;
  localparam logic [0:0] Z_WATER = 1'b1;

  typedef logic [2:0] zone_idx_t;

endpackage

// File: rtl/water_zone_ctrl_zone_hysteresis.sv
// Per-zone dry/wet hysteresis: demand sets below DRY_TH, clears at or above
// WET_TH, and holds in between.
module zone_hysteresis
  import water_zone_ctrl_pkg::*;
#(
  parameter int MOIST_W = DEF_MOIST_W,
  parameter int DRY_TH  = DEF_DRY_TH,
  parameter int WET_TH  = DEF_WET_TH
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [MOIST_W-1:0] moisture,
  output logic               dem
);

  // One extra bit so a threshold equal to 2**MOIST_W is still representable.
  localparam logic [MOIST_W:0] DRY_V = (MOIST_W + 1)'(DRY_TH);
  localparam logic [MOIST_W:0] WET_V = (MOIST_W + 1)'(WET_TH);

  logic dem_q;
  logic dem_d;

  always_comb begin
    dem_d = dem_q;
    if ({1'b0, moisture} < DRY_V) begin
      dem_d = 1'b1;
    end else if ({1'b0, moisture} >= WET_V) begin
      dem_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      dem_q <= 1'b0;
    end else begin
      dem_q <= dem_d;
    end
  end

  assign dem = dem_q;

endmodule

// File: rtl/water_zone_ctrl.sv
// Tank pump with minimum on-time plus a round-robin scheduler that waters one
// irrigation zone at a time, with per-turn timeout and dry-tank abort.
module water_zone_ctrl
  import water_zone_ctrl_pkg::*;
#(
  parameter int N_ZONES     = DEF_N_ZONES,
  parameter int MOIST_W     = DEF_MOIST_W,
  parameter int DRY_TH      = DEF_DRY_TH,
  parameter int WET_TH      = DEF_WET_TH,
  parameter int LVL_W       = DEF_LVL_W,
  parameter int PUMP_MIN_ON = DEF_PUMP_MIN_ON,
  parameter int WATER_MAX   = DEF_WATER_MAX
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [N_ZONES*MOIST_W-1:0] Moisture_sensor,
  input  logic [LVL_W-1:0]           Water_sensor,
  output logic                       Pump,
  output logic [N_ZONES-1:0]         Sprinkler,
  output logic                       Tank_low,
  output logic [2:0]                 Active_zone,
  output logic                       Timeout_flag
);

  localparam int ON_W = $clog2(PUMP_MIN_ON + 1);
  localparam int WC_W = (WATER_MAX > 1) ? $clog2(WATER_MAX) : 1;
  localparam logic [ON_W-1:0]  ON_SAT   = ON_W'(PUMP_MIN_ON);
  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(PUMP_MIN_ON - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(WATER_MAX - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = '1;

  logic [N_ZONES-1:0] dem;

  genvar gi;
  generate
    for (gi = 0; gi < N_ZONES; gi++) begin : g_zone
      zone_hysteresis #(
        .MOIST_W (MOIST_W),
        .DRY_TH  (DRY_TH),
        .WET_TH  (WET_TH)
      ) u_hyst (
        .CLK      (CLK),
        .Reset    (Reset),
        .moisture (Moisture_sensor[gi*MOIST_W +: MOIST_W]),
        .dem      (dem[gi])
      );
    end
  endgenerate

  logic tank_empty;
  logic tank_full;
  assign tank_empty = (Water_sensor == '0);
  assign tank_full  = (Water_sensor == LVL_FULL);

  // First demanding zone at or after 'start', wrapping modulo N_ZONES.
  function automatic void pick_zone(
    input  logic [N_ZONES-1:0] req,
    input  zone_idx_t          start,
    output logic               found,
    output zone_idx_t          idx,
    output logic [N_ZONES-1:0] oh
  );
    logic [N_ZONES-1:0] cand;
    int k;
    found = 1'b0;
    idx   = '0;
    oh    = '0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      k    = (int'(start) + i) % N_ZONES;
      cand = N_ZONES'(1) << k;
      if (|(req & cand)) begin
        found = 1'b1;
        idx   = zone_idx_t'(k);
        oh    = cand;
      end
    end
  endfunction

  logic [0:0]      pump_st_q, pump_st_d;
  logic [ON_W-1:0] on_cnt_q, on_cnt_d;

  always_comb begin
    pump_st_d = pump_st_q;
    on_cnt_d  = on_cnt_q;
    case (pump_st_q)
      P_OFF: begin
        if (tank_empty) begin
          pump_st_d = P_ON;
          on_cnt_d  = '0;
        end
      end
      default: begin
        if (tank_full && (on_cnt_q >= ON_LAST)) begin
          pump_st_d = P_OFF;
        end else if (on_cnt_q != ON_SAT) begin
          on_cnt_d = on_cnt_q + ON_W'(1);
        end
      end
    endcase
  end

  logic [0:0]         zone_st_q, zone_st_d;
  zone_idx_t          active_q, active_d;
  logic [N_ZONES-1:0] sprk_q, sprk_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  zone_idx_t          rr_q, rr_d;
  logic               tmo_q, tmo_d;
  logic               tank_low_q;
  logic               pick_found;
  zone_idx_t          pick_idx;
  logic [N_ZONES-1:0] pick_oh;
  logic               active_dem;

  // sprk_q is the one-hot of the active zone, so it selects that zone's demand.
  assign active_dem = |(dem & sprk_q);

  always_comb begin
    zone_st_d = zone_st_q;
    active_d  = active_q;
    sprk_d    = sprk_q;
    wcnt_d    = wcnt_q;
    rr_d      = rr_q;
    tmo_d     = 1'b0;
    pick_zone(dem, rr_q, pick_found, pick_idx, pick_oh);
    case (zone_st_q)
      Z_IDLE: begin
        if (pick_found && !tank_empty) begin
          zone_st_d = Z_WATER;
          active_d  = pick_idx;
          sprk_d    = pick_oh;
          wcnt_d    = '0;
        end
      end
      default: begin
        if (tank_empty || !active_dem || (wcnt_q == WC_LAST)) begin
          zone_st_d = Z_IDLE;
          active_d  = '0;
          sprk_d    = '0;
          wcnt_d    = '0;
          rr_d      = zone_idx_t'((int'(active_q) + 1) % N_ZONES);
          tmo_d     = !tank_empty && active_dem;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pump_st_q  <= P_OFF;
      on_cnt_q   <= '0;
      zone_st_q  <= Z_IDLE;
      active_q   <= '0;
      sprk_q     <= '0;
      wcnt_q     <= '0;
      rr_q       <= '0;
      tmo_q      <= 1'b0;
      tank_low_q <= 1'b0;
    end else begin
      pump_st_q  <= pump_st_d;
      on_cnt_q   <= on_cnt_d;
      zone_st_q  <= zone_st_d;
      active_q   <= active_d;
      sprk_q     <= sprk_d;
      wcnt_q     <= wcnt_d;
      rr_q       <= rr_d;
      tmo_q      <= tmo_d;
      tank_low_q <= tank_empty;
    end
  end

  assign Pump         = (pump_st_q == P_ON);
  assign Sprinkler    = sprk_q;
  assign Active_zone  = active_q;
  assign Timeout_flag = tmo_q;
  assign Tank_low     = tank_low_q;

endmodule

// File: tb/tb_water_zone_ctrl.sv
// Bench for water_zone_ctrl: directed scenarios followed by random moisture and
// tank-level traffic, all checked every cycle against a behavioural model.
module tb_water_zone_ctrl;
  import water_zone_ctrl_pkg::*;

  localparam int NZ       = 4;
  localparam int MW       = 8;
  localparam int DRY      = 64;
  localparam int WET      = 128;
  localparam int FULL     = 3;
  localparam int MIN_ON   = 8;
  localparam int WMAX     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NZ*MW-1:0]  moist;
  logic [1:0]        lvl;
  logic              pump;
  logic [NZ-1:0]     sprk;
  logic              tank_low;
  logic [2:0]        zone;
  logic              tmo;

  always #5 clk = ~clk;

  water_zone_ctrl #(
    .N_ZONES(NZ), .MOIST_W(MW), .DRY_TH(DRY), .WET_TH(WET),
    .LVL_W(2), .PUMP_MIN_ON(MIN_ON), .WATER_MAX(WMAX)
  ) dut (
    .CLK             (clk),
    .Reset           (rst),
    .Moisture_sensor (moist),
    .Water_sensor    (lvl),
    .Pump            (pump),
    .Sprinkler       (sprk),
    .Tank_low        (tank_low),
    .Active_zone     (zone),
    .Timeout_flag    (tmo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus values applied on the next cycle.
  int m_val[NZ];
  int lvl_v;
  bit rst_v;

  // Reference model: plain integers describing the observable behaviour.
  bit m_dem[NZ];
  bit m_pump;
  int m_age;      // cycles the pump has been running, capped at MIN_ON
  int m_cur;      // zone being watered, -1 when idle
  int m_turn;     // cycles the current zone has had its valve open
  int m_rr;
  bit m_tmo;
  bit m_low;

  task automatic model_step();
    bit leave;
    if (rst_v) begin
      foreach (m_dem[k]) m_dem[k] = 0;
      m_pump = 0; m_age = 0; m_cur = -1; m_turn = 0; m_rr = 0; m_tmo = 0; m_low = 0;
      return;
    end
    if (!m_pump) begin
      if (lvl_v == 0) begin m_pump = 1; m_age = 0; end
    end else if (lvl_v == FULL && m_age >= MIN_ON - 1) begin
      m_pump = 0;
    end else if (m_age < MIN_ON) begin
      m_age++;
    end
    m_tmo = 0;
    if (m_cur < 0) begin
      for (int i = 0; i < NZ; i++) begin
        int k;
        k = (m_rr + i) % NZ;
        if (m_dem[k]) begin
          if (lvl_v != 0) begin m_cur = k; m_turn = 1; end
          break;
        end
      end
    end else begin
      leave = 1;
      if (lvl_v == 0) ;
      else if (!m_dem[m_cur]) ;
      else if (m_turn == WMAX) m_tmo = 1;
      else begin leave = 0; m_turn++; end
      if (leave) begin m_rr = (m_cur + 1) % NZ; m_cur = -1; end
    end
    for (int k = 0; k < NZ; k++) begin
      if (m_val[k] < DRY) m_dem[k] = 1;
      else if (m_val[k] >= WET) m_dem[k] = 0;
    end
    m_low = (lvl_v == 0);
  endtask

  task automatic cycle();
    @(negedge clk);
    rst = rst_v;
    for (int k = 0; k < NZ; k++) moist[k*MW +: MW] = m_val[k][MW-1:0];
    lvl = lvl_v[1:0];
    @(posedge clk);
    model_step();
    #1;
    check("pump", pump, m_pump);
    check("sprinkler", sprk, (m_cur < 0) ? 0 : (1 << m_cur));
    check("active_zone", zone, (m_cur < 0) ? 0 : m_cur);
    check("tank_low", tank_low, m_low);
    check("timeout", tmo, m_tmo);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < NZ; k++) m_val[k] = v;
  endtask

  // Cycle until the model reaches zone z at turn t (t=0: any turn); bounded.
  task automatic wait_turn(input string tag, input int z, input int t, input int budget);
    int n;
    n = 0;
    while (!(m_cur == z && (t == 0 || m_turn == t)) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, m_cur, z);
  endtask

  int hi_cnt;

  initial begin
    rst_v = 1; lvl_v = 2; set_all(200);
    rst = 1; lvl = 2; moist = '1;
    m_cur = -1;
    run(2);
    rst_v = 0;
    run(3);

    // Hysteresis on zone 0: 32 -> 100 -> 64 -> 128.
    m_val[0] = 32;  run(4);
    m_val[0] = 100; run(3);
    m_val[0] = 64;  run(3);
    m_val[0] = 128; run(4);

    // Pump minimum on-time, tank reading full right after it empties.
    lvl_v = 3; run(12);
    lvl_v = 0; cycle();
    hi_cnt = int'(pump);
    lvl_v = 3;
    for (int i = 0; i < 12; i++) begin
      cycle();
      hi_cnt += int'(pump);
    end
    check("pump_min_on", hi_cnt, MIN_ON);
    lvl_v = 0; run(20);
    lvl_v = 3; run(3);

    // Timeout and fairness between zones 1 and 2.
    lvl_v = 2; m_val[1] = 10; m_val[2] = 10;
    run(75);
    set_all(200); run(4);

    // Dry-tank abort of zone 3 at wcnt=5, then recovery.
    m_val[3] = 10;
    wait_turn("wait_zone3", 3, 6, 40);
    lvl_v = 0; run(6);
    lvl_v = 2; run(4);
    m_val[3] = 200; run(3);

    // Wrap-around: leave rr at 3, then only zone 0 dry.
    m_val[2] = 10;
    wait_turn("wait_zone2", 2, 0, 40);
    m_val[2] = 200; run(4);
    m_val[0] = 10; run(4);
    m_val[0] = 200; run(3);

    // Reset held for 2 cycles mid-watering.
    m_val[1] = 10;
    wait_turn("wait_zone1", 1, 4, 40);
    lvl_v = 0; cycle();
    lvl_v = 2;
    rst_v = 1; run(2);
    rst_v = 0; run(3);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < NZ; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 6))
            0: m_val[k] = 10;
            1: m_val[k] = DRY - 1;
            2: m_val[k] = DRY;
            3: m_val[k] = WET - 1;
            4: m_val[k] = WET;
            5: m_val[k] = 220;
            default: m_val[k] = $urandom_range(0, 255);
          endcase
        end
      end
      if ($urandom_range(0, 5) == 0) lvl_v = $urandom_range(0, 3);
      rst_v = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst_v = 0;
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
